// File: rtl/fuec_cw_serializer_48_16.sv
// Serializes one CW_W-bit FUEC codeword per handshake into BEATS beats of BEAT_W bits, LSB beat first.
// Supports back-to-back codewords with no bubble and counts completed codewords.
module fuec_cw_serializer_48_16 #(
  parameter int CW_W   = 48,
  parameter int BEAT_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CW_W-1:0]               in_cw,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BEAT_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_first,
  output logic                          out_last,
  output logic [$clog2(CW_W/BEAT_W)-1:0] out_idx,
  output logic [CNT_W-1:0]              cw_count
);

  localparam int BEATS = CW_W / BEAT_W;
  localparam int IDX_W = $clog2(BEATS);

  if ((CW_W % BEAT_W) != 0 || BEATS < 2) begin : g_bad_params
    $error("fuec_cw_serializer_48_16: CW_W must be a multiple of BEAT_W with at least 2 beats");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  logic [CW_W-1:0]   hold;
  logic [IDX_W-1:0]  idx;
  logic [BEAT_W-1:0] beat_slices [BEATS];
  logic              is_last;
  logic              beat_xfer;

  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    assign beat_slices[g] = hold[g*BEAT_W +: BEAT_W];
  end

  assign is_last   = (idx == IDX_W'(BEATS-1));
  assign out_valid = (state == SEND);
  assign beat_xfer = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | ((state == SEND) & is_last & out_ready);

  // Outputs decode directly from registered state so reset clears them asynchronously.
  assign out_data  = (state == SEND) ? beat_slices[idx] : '0;
  assign out_first = (state == SEND) & (idx == '0);
  assign out_last  = (state == SEND) & is_last;
  assign out_idx   = (state == SEND) ? idx : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      idx      <= '0;
      cw_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_cw;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (beat_xfer) begin
            if (is_last) begin
              cw_count <= cw_count + CNT_W'(1);
              if (in_valid) begin
                hold <= in_cw;
                idx  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuec_cw_serializer_48_16.sv
// Directed table-driven bench for fuec_cw_serializer_48_16 plus reset, random reassembly and counter-wrap sequences.
module tb_fuec_cw_serializer_48_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] in_cw;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [15:0] out_data, out_data4;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic        out_first, out_first4;
  logic        out_last, out_last4;
  logic [1:0]  out_idx, out_idx4;
  logic [15:0] cw_count;
  logic [3:0]  cw_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fuec_cw_serializer_48_16 dut (
    .clk(clk), .rst(rst), .in_cw(in_cw), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .out_idx(out_idx), .cw_count(cw_count)
  );

  fuec_cw_serializer_48_16 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_cw(in_cw), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_first(out_first4), .out_last(out_last4), .out_idx(out_idx4), .cw_count(cw_count4)
  );

  typedef struct {
    logic [47:0] cw;
    logic        iv;
    logic        ordy;
    logic        ov;
    logic [15:0] d;
    logic        f;
    logic        l;
    logic [1:0]  ix;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [47:0] cw, logic iv, logic ordy, logic ov,
                              logic [15:0] d, logic f, logic l, logic [1:0] ix, logic ir);
    vec_t v;
    v.cw = cw; v.iv = iv; v.ordy = ordy; v.ov = ov; v.d = d;
    v.f = f; v.l = l; v.ix = ix; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one codeword from IDLE and collects its beats under random backpressure.
  task automatic send_word(input logic [47:0] cw, input bit random_stall);
    logic [15:0] b [3];
    int got;
    int budget;
    in_cw = cw;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cw = 48'h0;
    got = 0;
    budget = 0;
    while (got < 3 && budget < 40) begin
      out_ready = random_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_idx != 2'(got)) chk("beat_order", 64'(out_idx), 64'(got));
        b[got] = out_data;
        got++;
      end
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b1;
    if (got < 3) chk("beat_timeout", 64'(got), 64'd3);
    else chk("reassembled_cw", 64'({b[2], b[1], b[0]}), 64'(cw));
  endtask

  initial begin
    rst = 1'b1; in_cw = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready), 64'd1);
    chk("reset_out_data",  64'(out_data), 64'd0);
    chk("reset_cw_count",  64'(cw_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    //                   cw                iv    ordy  ov    data      f     l     idx   in_ready
    vecs.push_back(mk(48'hA5A5_1234_5678, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(48'h0000_0000_FFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(48'h1111_2222_3333, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(48'h1111_2222_3333, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h1111_2222_3333, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(48'hDEAD_BEEF_CAFE, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(48'hDEAD_BEEF_CAFE, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'hDEAD_BEEF_CAFE, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h1234_5678_9ABC, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h1234_5678_9ABC, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h1234_5678_9ABC, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(48'h0102_0304_0506, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'h0506, 1'b1, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'h0304, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b1, 16'h0102, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(48'h0,              1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1));

    foreach (vecs[i]) begin
      in_cw = vecs[i].cw; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_out_data", i),  64'(out_data),  64'(vecs[i].d));
      chk($sformatf("v%0d_out_first", i), 64'(out_first), 64'(vecs[i].f));
      chk($sformatf("v%0d_out_last", i),  64'(out_last),  64'(vecs[i].l));
      chk($sformatf("v%0d_out_idx", i),   64'(out_idx),   64'(vecs[i].ix));
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].ir));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("count_after_table", 64'(cw_count), 64'd5);
    chk("count4_after_table", 64'(cw_count4), 64'd5);

    // Asynchronous reset in the middle of a codeword.
    in_cw = 48'h7777_8888_9999; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_idx", 64'(out_idx), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_cw_count",  64'(cw_count),  64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      send_word({$urandom(), 16'($urandom())}, 1'b1);
    end
    chk("count_after_random", 64'(cw_count), 64'd40);
    chk("count4_after_random", 64'(cw_count4), 64'd8);

    // Narrow counter wraps: 17 codewords on a 4-bit counter reads 1.
    #2; rst = 1'b1; #2;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      send_word(48'h0000_0001_0000 * 48'(k) + 48'h00AB, 1'b0);
    end
    chk("count4_wrap", 64'(cw_count4), 64'd1);
    chk("count16_no_wrap", 64'(cw_count), 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
